seq_mult16: RTL
===============

Name: seq_mult16

Overview:
- Iterative shift-add unsigned multiplier, 16x16 -> 32.
- Sits directly upstream of the team's 16-bit carry-lookahead adder and drives both of its operands every cycle.
- Consumes the adder's sum and carry-out, then shifts the result back into its own product register.
- Serves as the multi-cycle MULT unit beside the ALU. One adder is reused for all iterations, so no array multiplier is built.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported, to match the adder; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; accepted only when ready=1.
- flush  in  1  synchronous abort of an in-flight multiply.
- mcand  in  16  multiplicand; sampled on the accepted start.
- mplier  in  16  multiplier; sampled on the accepted start.
- ready  out  1  high in IDLE and DONE; a new start is accepted.
- busy  out  1  high while iterating (RUN).
- done  out  1  one-cycle pulse when the product becomes valid.
- product  out  32  result; held stable until the next accepted start.
- ovf  out  1  product[31:16] != 0; valid with product.
- add_a  out  16  adder operand A: current upper accumulator half.
- add_b  out  16  adder operand B: multiplicand register when lo[0]=1, else 0.
- add_sum  in  16  adder Out, returned to this block.
- add_c16  in  1  adder carry-out C16. Adder C0 is tied 0 externally.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; P register (33 bits: {cy, hi[15:0], lo[15:0]}), mcand register and count all clear to 0.
  - Outputs: ready=1, busy=0, done=0, product=0, ovf=0.
- Reset asserted mid-RUN kills the operation immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with start=1 (flush=0), on the next edge:
  - latch mcand into the multiplicand register;
  - P={1'b0, 16'h0, mplier}; count=0; state=RUN.
- Start while busy=1 is ignored, with no side effects.
- RUN, each cycle:
  - add_a=hi; add_b = lo[0] ? mcand_reg : 0.
  - Next edge: P <= {1'b0, add_c16, add_sum, lo[15:1]}. This is a right shift of the 33-bit {carry, sum, lo}; the top bit of the register is always 0 after the shift.
  - count increments.
- count==15 in RUN: the last iteration completes; on that edge state=DONE and done=1 for exactly one cycle.
- product = {hi, lo}, valid from the cycle done is high; ovf is registered alongside it.
- Latency: start sampled at edge 0, done high after edge 16.
  - Exactly 16 RUN cycles; fixed, no early exit, even for zero operands.
- DONE: product and ovf hold. State stays DONE until the next start, and done deasserts after one cycle.
  - start in DONE behaves as in IDLE (back-to-back issue, one dead cycle minimum).
- flush=1 in RUN:
  - next edge state=IDLE; product and ovf keep their previous completed values; done stays 0.
- flush in IDLE or DONE: no effect.
- flush and start in the same cycle: flush wins, start is dropped.
- Outside RUN: add_a=0 and add_b=0, so the shared adder sees no toggling.
- Arithmetic:
  - Purely unsigned; the 32-bit product never overflows internally.
  - The carry from each 16-bit add must be captured through add_c16; dropping it is a functional bug.

Test Plan:
- Reset, then start with mcand=0x0003, mplier=0x0005 -> busy for 16 cycles, done pulse at cycle 16, product=0x0000000F, ovf=0, ready=1 afterwards.
- mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001, ovf=1; checks carry capture on every iteration.
- mcand=0x1234, mplier=0x0000 -> product=0, ovf=0, still exactly 16 cycles. Then mcand=0x8000, mplier=0x0002 -> product=0x00010000, ovf=1.
- Start mcand=0x00FF, mplier=0x0101; pulse start again at cycle 5 with 0xAAAA/0xAAAA -> second request ignored, product=0x0000FFFF at cycle 16.
- Complete 7*9=0x3F; start 0x1000*0x1000; assert flush at cycle 8 -> IDLE next cycle, no done, product still 0x0000003F.
- Drop rst_n at cycle 10 of a 0xFFFF*0x0002 run -> immediate IDLE, product=0, ready=1. After release, a 2*2 start gives product=4.

Source files
------------

// File: rtl/seq_mult16.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_mult16
//   Iterative shift-add unsigned multiplier, 16x16 -> 32. It does not contain
//   its own adder. Each RUN cycle it sends the upper accumulator half and the
//   gated multiplicand to an external 16-bit carry-lookahead adder. It then
//   takes back the adder's sum and carry-out and shifts them into the partial
//   product register. A multiply always takes exactly 16 RUN cycles.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request pulse, accepted only while ready=1 and flush=0
//   flush    in   1   synchronous abort of an in-flight multiply
//   mcand    in  16   multiplicand, sampled on the accepted start
//   mplier   in  16   multiplier, sampled on the accepted start
//   ready    out  1   IDLE or DONE: a new start is accepted
//   busy     out  1   iterating (RUN)
//   done     out  1   one-cycle pulse when product becomes valid
//   product  out 32   last completed result, held until the next completion
//   ovf      out  1   product[31:16] != 0, valid with product
//   add_a    out 16   adder operand A (upper accumulator half, 0 outside RUN)
//   add_b    out 16   adder operand B (mcand when lo[0]=1, 0 outside RUN)
//   add_sum  in  16   adder sum
//   add_c16  in   1   adder carry-out (adder carry-in is tied 0 externally)
// -----------------------------------------------------------------------------
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_c16
);

    // The external adder is fixed at 16 bits.
    generate
        if (WIDTH != 16) begin : g_bad_width
            $error("seq_mult16: only WIDTH=16 is supported");
        end
    endgenerate

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    // Partial product {hi, lo}. The conceptual 33rd (carry) bit is always zero
    // after each shift. The live carry only exists on add_c16 within the
    // cycle, so that bit is not stored.
    logic [2*WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_count;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_ovf;

    logic                 w_run;
    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_lo;
    logic [2*WIDTH-1:0]   w_shift;

    assign w_run = (r_state == S_RUN);
    assign w_hi  = r_p[2*WIDTH-1:WIDTH];
    assign w_lo  = r_p[WIDTH-1:0];

    // Right shift of {carry, sum, lo} by one. The lo bit that was just
    // consumed drops out.
    assign w_shift = {add_c16, add_sum, w_lo[WIDTH-1:1]};

    // Adder operands are forced to zero outside RUN, so the shared adder does
    // not toggle while this unit is idle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_operands
            assign add_a[gi] = w_run & w_hi[gi];
            assign add_b[gi] = w_run & w_lo[0] & r_mcand[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // flush has priority: a start that arrives with flush is dropped
                    if (start && !flush) begin
                        r_mcand <= mcand;
                        r_p     <= {{WIDTH{1'b0}}, mplier};
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_p     <= w_shift;
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_COUNT) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_product <= w_shift;
                            r_ovf     <= |w_shift[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready   = (r_state != S_RUN);
    assign busy    = w_run;
    assign done    = r_done;
    assign product = r_product;
    assign ovf     = r_ovf;

endmodule
